// File: rtl/game_pkg.sv
// game_pkg: phase encodings and BCD digit width shared by the game-flow controller.
package game_pkg;
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] PLAY    = 3'd1;
  localparam logic [2:0] NEWBALL = 3'd2;
  localparam logic [2:0] OVER    = 3'd3;
  localparam logic [2:0] PAUSE   = 3'd4;
  localparam int BCD_W = 4;
endpackage

// File: rtl/bcd_counter.sv
// bcd_counter: multi-digit BCD up-counter with clear and saturation at all-9s.
module bcd_counter
  import game_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    inc,
  output logic [BCD_W*DIGITS-1:0] count
);
  logic [BCD_W*DIGITS-1:0] nxt;
  logic [BCD_W-1:0] d;
  logic c;
  always_comb begin
    nxt = count;
    d = '0;
    c = inc && count != {DIGITS{4'h9}};
    for (int i = 0; i < DIGITS; i++) begin
      d = count[BCD_W*i +: BCD_W];
      nxt[BCD_W*i +: BCD_W] = c ? (d == 4'd9 ? 4'd0 : d + 4'd1) : d;
      c = c && d == 4'd9;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else count <= clr ? '0 : nxt;
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: phase FSM, lives, BCD score and post-miss wait timer for the bounce game.
// Optional high-score register enabled by defining GAME_HISCORE_EN.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int SCORE_DIGITS = 2,
  parameter int WAIT_FRAMES  = 120
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic                          btn,
  input  logic                          pause_btn,
  input  logic                          hit,
  input  logic                          miss,
  output logic [2:0]                    phase,
  output logic                          gra_still,
  output logic [3:0]                    lives,
  output logic [BCD_W*SCORE_DIGITS-1:0] score,
  output logic [BCD_W*SCORE_DIGITS-1:0] hi_score,
  output logic                          new_high,
  output logic                          timer_busy
);
  localparam int TW = $clog2(WAIT_FRAMES + 1);
  logic [2:0] nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic btn_c, btn_p, pb_c, pb_p, btn_e, pb_e, in_play;
  assign btn_e = btn_c & ~btn_p;
  assign pb_e = pb_c & ~pb_p;
  assign in_play = phase == PLAY;
  // miss outranks pause; the timer load outranks a coincident frame tick
  always_comb begin
    nxt = phase;
    case (phase)
      IDLE:    nxt = btn_e ? PLAY : IDLE;
      PLAY:    nxt = miss ? (lives == 4'd0 ? OVER : NEWBALL) : pb_e ? PAUSE : PLAY;
      PAUSE:   nxt = pb_e ? PLAY : PAUSE;
      NEWBALL: nxt = (timer == '0 && btn_e) ? PLAY : NEWBALL;
      OVER:    nxt = timer == '0 ? IDLE : OVER;
      default: nxt = IDLE;
    endcase
    timer_nxt = (in_play && miss) ? TW'(WAIT_FRAMES) :
                (frame_tick && timer != '0 && phase != PAUSE) ? timer - TW'(1) : timer;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      phase <= IDLE;
      gra_still <= 1'b1;
      lives <= 4'(LIVES);
      timer <= '0;
      timer_busy <= 1'b0;
      btn_c <= 1'b0;
      btn_p <= 1'b0;
      pb_c <= 1'b0;
      pb_p <= 1'b0;
    end else begin
      btn_c <= btn;
      btn_p <= btn_c;
      pb_c <= pause_btn;
      pb_p <= pb_c;
      phase <= nxt;
      gra_still <= nxt != PLAY;
      timer <= timer_nxt;
      timer_busy <= timer_nxt != '0;
      lives <= phase == IDLE ? (btn_e ? 4'(LIVES - 1) : 4'(LIVES)) :
               (in_play && miss && lives != 4'd0) ? lives - 4'd1 : lives;
    end
  bcd_counter #(.DIGITS(SCORE_DIGITS)) u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (phase == IDLE),
    .inc   (in_play && hit && !miss),
    .count (score)
  );
`ifdef GAME_HISCORE_EN
  logic beat;
  // valid BCD orders the same as binary, so a plain compare is MSD-first
  assign beat = in_play && miss && lives == 4'd0 && score > hi_score;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hi_score <= '0;
      new_high <= 1'b0;
    end else begin
      new_high <= beat;
      if (beat) hi_score <= score;
    end
`else
  assign hi_score = '0;
  assign new_high = 1'b0;
`endif
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed scoreboard bench for game_flow_ctrl with default parameters.
module tb_game_flow_ctrl;
  import game_pkg::*;
`ifdef GAME_HISCORE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, frame_tick = 1'b0, btn = 1'b0, pause_btn = 1'b0, hit = 1'b0, miss = 1'b0;
  logic [2:0] phase;
  logic gra_still, new_high, timer_busy;
  logic [3:0] lives;
  logic [7:0] score, hi_score;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  string tag_q[$];
  always #5 clk = ~clk;
  game_flow_ctrl #(.LIVES(3), .SCORE_DIGITS(2), .WAIT_FRAMES(120)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn), .pause_btn(pause_btn),
    .hit(hit), .miss(miss), .phase(phase), .gra_still(gra_still), .lives(lives),
    .score(score), .hi_score(hi_score), .new_high(new_high), .timer_busy(timer_busy)
  );
  task automatic push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask
  task automatic cmp(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", t, obs, e);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press_b();
    btn = 1'b1; cyc(3); btn = 1'b0; cyc(1);
  endtask
  task automatic press_p();
    pause_btn = 1'b1; cyc(3); pause_btn = 1'b0; cyc(1);
  endtask
  task automatic hits(input int n);
    repeat (n) begin hit = 1'b1; cyc(1); hit = 1'b0; cyc(1); end
  endtask
  task automatic ticks(input int n);
    repeat (n) begin frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(1); end
  endtask
  task automatic do_miss();
    miss = 1'b1; cyc(1); miss = 1'b0; cyc(1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end
  initial begin
    cyc(2);
    reset = 1'b0;
    cyc(1);
    push("rst_phase", 32'(IDLE)); push("rst_still", 1); push("rst_lives", 3);
    push("rst_score", 0); push("rst_hi", 0); push("rst_nh", 0); push("rst_busy", 0);
    cmp(32'(phase)); cmp(32'(gra_still)); cmp(32'(lives));
    cmp(32'(score)); cmp(32'(hi_score)); cmp(32'(new_high)); cmp(32'(timer_busy));
    push("start_phase", 32'(PLAY)); push("start_lives", 2); push("start_still", 0);
    press_b();
    cmp(32'(phase)); cmp(32'(lives)); cmp(32'(gra_still));
    push("hit3_score", 32'h03);
    hits(3);
    cmp(32'(score));
    push("pause_phase", 32'(PAUSE)); push("pause_still", 1);
    press_p();
    cmp(32'(phase)); cmp(32'(gra_still));
    push("pause_score", 32'h03); push("pause_busy", 0); push("pause_hold", 32'(PAUSE));
    hits(1); ticks(50);
    cmp(32'(score)); cmp(32'(timer_busy)); cmp(32'(phase));
    push("resume_phase", 32'(PLAY)); push("resume_still", 0);
    press_p();
    cmp(32'(phase)); cmp(32'(gra_still));
    push("hm_score", 32'h03); push("hm_phase", 32'(NEWBALL)); push("hm_lives", 1); push("hm_busy", 1);
    hit = 1'b1; miss = 1'b1; cyc(1); hit = 1'b0; miss = 1'b0; cyc(1);
    cmp(32'(score)); cmp(32'(phase)); cmp(32'(lives)); cmp(32'(timer_busy));
    push("early_btn", 32'(NEWBALL));
    press_b();
    cmp(32'(phase));
    push("t119_busy", 1);
    ticks(119);
    cmp(32'(timer_busy));
    push("t120_busy", 0); push("t120_phase", 32'(NEWBALL));
    ticks(1);
    cmp(32'(timer_busy)); cmp(32'(phase));
    push("ball2_phase", 32'(PLAY)); push("ball2_lives", 1);
    press_b();
    cmp(32'(phase)); cmp(32'(lives));
    push("miss2_phase", 32'(NEWBALL)); push("miss2_lives", 0);
    do_miss();
    cmp(32'(phase)); cmp(32'(lives));
    push("ball3_phase", 32'(PLAY));
    ticks(120); press_b();
    cmp(32'(phase));
    push("carry_score", 32'h10);
    hits(7);
    cmp(32'(score));
    push("over_phase", 32'(OVER)); push("over_nh", 32'(HS)); push("over_hi", HS ? 32'h10 : 32'h0);
    push("over_lives", 0); push("over_busy", 1); push("over_still", 1);
    miss = 1'b1; cyc(1);
    cmp(32'(phase)); cmp(32'(new_high)); cmp(32'(hi_score));
    cmp(32'(lives)); cmp(32'(timer_busy)); cmp(32'(gra_still));
    push("nh_drop", 0);
    miss = 1'b0; cyc(1);
    cmp(32'(new_high));
    push("over_wait", 32'(OVER));
    ticks(119);
    cmp(32'(phase));
    push("idle_phase", 32'(IDLE)); push("idle_lives", 3); push("idle_score", 0);
    ticks(1); cyc(1);
    cmp(32'(phase)); cmp(32'(lives)); cmp(32'(score));
    press_b(); hits(5);
    do_miss(); ticks(120); press_b();
    do_miss(); ticks(120); press_b();
    push("g2_score", 32'h05);
    cmp(32'(score));
    push("g2_phase", 32'(OVER)); push("g2_nh", 0); push("g2_hi", HS ? 32'h10 : 32'h0);
    miss = 1'b1; cyc(1); miss = 1'b0;
    cmp(32'(phase)); cmp(32'(new_high)); cmp(32'(hi_score));
    push("g2_idle", 32'(IDLE));
    ticks(120); cyc(1);
    cmp(32'(phase));
    push("sat_99", 32'h99);
    press_b(); hits(99);
    cmp(32'(score));
    push("sat_hold", 32'h99);
    hits(5);
    cmp(32'(score));
    push("rst_mid_phase", 32'(IDLE)); push("rst_mid_busy", 0); push("rst_mid_lives", 3);
    push("rst_mid_score", 0); push("rst_mid_hi", 0); push("rst_mid_still", 1);
    do_miss();
    reset = 1'b1; #1;
    cmp(32'(phase)); cmp(32'(timer_busy)); cmp(32'(lives));
    cmp(32'(score)); cmp(32'(hi_score)); cmp(32'(gra_still));
    cyc(1); reset = 1'b0; cyc(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
